// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-drain line enables
module ps2_host_tx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_kbd_clk,
    input  logic       ps2_kbd_data,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);
    localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int MAX_CYC     = TIMEOUT_CYC > INHIBIT_CYC ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int CW          = $clog2(MAX_CYC + 1);
    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, PARITY, STOP, ACK, WAITIDLE} state_t;
    state_t        state_q;
    logic [1:0]    clk_sync_q, dat_sync_q;
    logic [3:0]    hist_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    byte_q;
    logic          clk_oe_q, dat_oe_q, ready_q, done_q, error_q;
    logic          clk_s, dat_s, fall, expired;
    assign clk_s      = clk_sync_q[1];
    assign dat_s      = dat_sync_q[1];
    assign fall       = hist_q == 4'b0001;
    assign expired    = cnt_q == CW'(TIMEOUT_CYC - 1);
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign tx_ready   = ready_q;
    assign busy       = ~ready_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            hist_q     <= 4'b1111;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_kbd_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_kbd_data};
            hist_q     <= {clk_s, hist_q[3:1]};
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    if (tx_valid && ready_q && clk_s) begin
                        byte_q   <= tx_data;
                        ready_q  <= 1'b0;
                        clk_oe_q <= 1'b1;
                        state_q  <= INHIBIT;
                    end
                end
                INHIBIT: if (cnt_q == CW'(INHIBIT_CYC - 1)) begin
                    dat_oe_q <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= RTS;
                end
                // timeout runs from RTS onward and takes priority over any coincident fall
                default: if (expired) begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    error_q  <= 1'b1;
                    state_q  <= IDLE;
                end else begin
                    case (state_q)
                        RTS: begin
                            clk_oe_q <= 1'b0;
                            bit_q    <= '0;
                            state_q  <= DATA;
                        end
                        DATA: if (fall) begin
                            dat_oe_q <= ~byte_q[bit_q];
                            bit_q    <= bit_q + 3'd1;
                            state_q  <= bit_q == 3'd7 ? PARITY : DATA;
                        end
                        PARITY: if (fall) begin
                            dat_oe_q <= ^byte_q;
                            state_q  <= STOP;
                        end
                        STOP: if (fall) begin
                            dat_oe_q <= 1'b0;
                            state_q  <= ACK;
                        end
                        ACK: if (fall) begin
                            error_q <= dat_s;
                            state_q <= dat_s ? IDLE : WAITIDLE;
                        end
                        WAITIDLE: if (clk_s && dat_s) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end
endmodule
